// File: rtl/br_predictor_gs2.sv
// br_predictor_gs2: gshare PHT + direct-mapped BTB front-end predictor with speculative GHR.
// Define BRPRED_PERF_CNT_EN to build the predicted-taken / mispredict counters.
module br_predictor_gs2 #(
  parameter int FETCH_W  = 2,
  parameter int PC_W     = 32,
  parameter int BTB_ENTS = 64,
  parameter int PHT_ENTS = 256,
  parameter int GHR_W    = 8,
  localparam int LANE_W  = FETCH_W > 1 ? $clog2(FETCH_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [FETCH_W-1:0] i_lane_vld,
  input  logic              i_fetch_adv,
  output logic [GHR_W-1:0]  o_ghr,
  output logic              o_pred_taken,
  output logic [LANE_W-1:0] o_pred_lane,
  output logic [PC_W-1:0]   o_pred_tgt,
  input  logic              i_com_br,
  input  logic [PC_W-1:0]   i_com_pc,
  input  logic [GHR_W-1:0]  i_com_ghr,
  input  logic [PC_W-1:0]   i_com_tgt,
  input  logic              i_com_taken,
  input  logic              i_com_mispred,
  output logic [31:0]       o_perf_pred,
  output logic [31:0]       o_perf_mispred
);
  localparam int BI    = $clog2(BTB_ENTS);
  localparam int TAG_W = PC_W - 2 - BI;
  if (GHR_W != $clog2(PHT_ENTS)) begin : g_bad_ghr
    $error("GHR_W must equal log2(PHT_ENTS)");
  end
  logic                 btb_vld [BTB_ENTS];
  logic [TAG_W-1:0]     btb_tag [BTB_ENTS];
  logic [PC_W-1:0]      btb_tgt [BTB_ENTS];
  logic [1:0]           pht [PHT_ENTS];
  logic [GHR_W-1:0]     ghr;
  logic [FETCH_W-1:0]   hit, taken;
  logic [PC_W-1:0]      lane_tgt [FETCH_W];
  logic [BI-1:0]        cbi;
  logic [GHR_W-1:0]     cpi;
  logic                 unused_lsb;
  assign cbi = i_com_pc[2 +: BI];
  assign cpi = i_com_pc[2 +: GHR_W] ^ i_com_ghr;
  assign unused_lsb = ^{i_pc[1:0], i_com_pc[1:0]};
  // Lane PCs are kept as word addresses so the +4*k carry wraps modulo 2^PC_W.
  for (genvar k = 0; k < FETCH_W; k++) begin : g_lane
    logic [PC_W-3:0] w;
    assign w           = i_pc[PC_W-1:2] + (PC_W-2)'(k);
    assign hit[k]      = i_lane_vld[k] & btb_vld[w[BI-1:0]] & (btb_tag[w[BI-1:0]] == w[PC_W-3:BI]);
    assign taken[k]    = hit[k] & pht[w[GHR_W-1:0] ^ ghr][1];
    assign lane_tgt[k] = btb_tgt[w[BI-1:0]];
  end
  always_comb begin
    o_pred_lane = '0;
    o_pred_tgt  = '0;
    for (int k = FETCH_W - 1; k >= 0; k--) begin
      o_pred_lane = taken[k] ? LANE_W'(k) : o_pred_lane;
      o_pred_tgt  = taken[k] ? lane_tgt[k] : o_pred_tgt;
    end
  end
  assign o_pred_taken = |taken;
  assign o_ghr        = ghr;
  // Commit repair outranks the speculative shift from the same cycle.
  always_ff @(posedge clk) begin
    if (rst) ghr <= '0;
    else if (i_com_br & i_com_mispred) ghr <= {i_com_ghr[GHR_W-2:0], i_com_taken};
    else if (i_fetch_adv & |hit) ghr <= {ghr[GHR_W-2:0], o_pred_taken};
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < PHT_ENTS; i++) pht[i] <= 2'b01;
    else if (i_com_br)
      pht[cpi] <= i_com_taken ? (pht[cpi] == 2'b11 ? 2'b11 : pht[cpi] + 2'b01)
                              : (pht[cpi] == 2'b00 ? 2'b00 : pht[cpi] - 2'b01);
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < BTB_ENTS; i++) btb_vld[i] <= 1'b0;
    else if (i_com_br & i_com_taken) btb_vld[cbi] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst && i_com_br && i_com_taken) begin
      btb_tag[cbi] <= i_com_pc[PC_W-1:2+BI];
      btb_tgt[cbi] <= i_com_tgt;
    end
  end
`ifdef BRPRED_PERF_CNT_EN
  logic [31:0] perf_pred, perf_mis;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_pred <= '0;
      perf_mis  <= '0;
    end else begin
      if (i_fetch_adv & o_pred_taken) perf_pred <= perf_pred + 32'd1;
      if (i_com_br & i_com_mispred) perf_mis <= perf_mis + 32'd1;
    end
  end
  assign o_perf_pred    = perf_pred;
  assign o_perf_mispred = perf_mis;
`else
  assign o_perf_pred    = '0;
  assign o_perf_mispred = '0;
`endif
endmodule

// File: tb/tb_br_predictor_gs2.sv
// tb_br_predictor_gs2: directed test-plan steps then random traffic against a table-based reference model.
module tb_br_predictor_gs2;
`ifdef BRPRED_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [31:0] i_pc, i_com_pc, i_com_tgt, o_pred_tgt, o_perf_pred, o_perf_mispred;
  logic [1:0] i_lane_vld;
  logic i_fetch_adv, i_com_br, i_com_taken, i_com_mispred, o_pred_taken;
  logic [0:0] o_pred_lane;
  logic [7:0] o_ghr, i_com_ghr;
  int checks = 0, errors = 0;
  bit m_vld [64];
  logic [31:0] m_tag [64], m_tgt [64];
  int m_pht [256];
  logic [7:0] m_ghr;
  logic [31:0] m_pp, m_pm;
  logic e_taken, e_hit;
  logic [0:0] e_lane;
  logic [31:0] e_tgt;

  br_predictor_gs2 dut (
    .clk(clk), .rst(rst), .i_pc(i_pc), .i_lane_vld(i_lane_vld), .i_fetch_adv(i_fetch_adv),
    .o_ghr(o_ghr), .o_pred_taken(o_pred_taken), .o_pred_lane(o_pred_lane), .o_pred_tgt(o_pred_tgt),
    .i_com_br(i_com_br), .i_com_pc(i_com_pc), .i_com_ghr(i_com_ghr), .i_com_tgt(i_com_tgt),
    .i_com_taken(i_com_taken), .i_com_mispred(i_com_mispred),
    .o_perf_pred(o_perf_pred), .o_perf_mispred(o_perf_mispred)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_pp = 0;
    m_pm = 0;
  endfunction

  function automatic void predict();
    e_taken = 0; e_hit = 0; e_lane = 0; e_tgt = 0;
    for (int k = 1; k >= 0; k--) begin
      logic [31:0] lp = i_pc + 32'(4 * k);
      int bi = int'((lp >> 2) % 64);
      int pi = int'(((lp >> 2) % 256) ^ {24'd0, m_ghr});
      bit h = i_lane_vld[k] && m_vld[bi] && m_tag[bi] == (lp >> 8);
      if (h) e_hit = 1;
      if (h && m_pht[pi] >= 2) begin
        e_taken = 1; e_lane = 1'(k); e_tgt = m_tgt[bi];
      end
    end
  endfunction

  function automatic void update();
    if (rst) begin
      model_reset();
      return;
    end
    if (i_fetch_adv && e_taken) m_pp++;
    if (i_com_br && i_com_mispred) begin
      m_pm++;
      m_ghr = 8'(i_com_ghr * 2 + i_com_taken);
    end else if (i_fetch_adv && e_hit) m_ghr = 8'(m_ghr * 2 + e_taken);
    if (i_com_br) begin
      int pi = int'(((i_com_pc >> 2) % 256) ^ {24'd0, i_com_ghr});
      m_pht[pi] = i_com_taken ? (m_pht[pi] < 3 ? m_pht[pi] + 1 : 3) : (m_pht[pi] > 0 ? m_pht[pi] - 1 : 0);
      if (i_com_taken) begin
        int bi = int'((i_com_pc >> 2) % 64);
        m_vld[bi] = 1'b1;
        m_tag[bi] = i_com_pc >> 8;
        m_tgt[bi] = i_com_tgt;
      end
    end
  endfunction

  task automatic look();
    @(negedge clk);
    predict();
    check("pred_taken", {31'd0, o_pred_taken}, {31'd0, e_taken});
    check("pred_lane", {31'd0, o_pred_lane}, {31'd0, e_lane});
    check("pred_tgt", o_pred_tgt, e_tgt);
    check("ghr", {24'd0, o_ghr}, {24'd0, m_ghr});
    check("perf_pred", o_perf_pred, PERF ? m_pp : 32'd0);
    check("perf_mispred", o_perf_mispred, PERF ? m_pm : 32'd0);
  endtask

  task automatic adv();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [7:0] g, input logic [31:0] tgt,
                        input logic tk, input logic mis);
    i_com_br = 1; i_com_pc = pc; i_com_ghr = g; i_com_tgt = tgt; i_com_taken = tk; i_com_mispred = mis;
    look();
    adv();
    i_com_br = 0; i_com_mispred = 0;
  endtask

  initial begin
    rst = 1; i_pc = 32'h100; i_lane_vld = 2'b11; i_fetch_adv = 0;
    i_com_br = 0; i_com_pc = 0; i_com_ghr = 0; i_com_tgt = 0; i_com_taken = 0; i_com_mispred = 0;
    @(posedge clk);
    model_reset();
    #1;
    look();
    check("rst_taken", {31'd0, o_pred_taken}, 32'd0);
    check("rst_lane", {31'd0, o_pred_lane}, 32'd0);
    check("rst_tgt", o_pred_tgt, 32'd0);
    check("rst_ghr", {24'd0, o_ghr}, 32'd0);
    adv();
    rst = 0;
    // BTB fill and warm-up of lane 1 of 0x1000
    i_lane_vld = 2'b00;
    commit(32'h1004, 8'h00, 32'h2000, 1, 0);
    i_pc = 32'h1000; i_lane_vld = 2'b11;
    look();
    check("warm_taken", {31'd0, o_pred_taken}, 32'd1);
    check("warm_lane", {31'd0, o_pred_lane}, 32'd1);
    check("warm_tgt", o_pred_tgt, 32'h2000);
    adv();
    // two strongly-taken lanes; also warm the GHR=3 entry for 0x3000
    for (int n = 0; n < 2; n++) commit(32'h3000, 8'h00, 32'h3000, 1, 0);
    for (int n = 0; n < 2; n++) commit(32'h3004, 8'h00, 32'h4000, 1, 0);
    for (int n = 0; n < 2; n++) commit(32'h3000, 8'h03, 32'h3000, 1, 0);
    i_pc = 32'h3000; i_lane_vld = 2'b11;
    look();
    check("sel_lane0", {31'd0, o_pred_lane}, 32'd0);
    check("sel_tgt0", o_pred_tgt, 32'h3000);
    adv();
    i_lane_vld = 2'b10;
    look();
    check("sel_lane1", {31'd0, o_pred_lane}, 32'd1);
    check("sel_tgt1", o_pred_tgt, 32'h4000);
    adv();
    // GHR speculation then repair
    i_lane_vld = 2'b11; i_fetch_adv = 1;
    for (int n = 0; n < 3; n++) begin
      look();
      adv();
    end
    i_com_br = 1; i_com_pc = 32'h5000; i_com_ghr = 8'h01; i_com_tgt = 0; i_com_taken = 0; i_com_mispred = 1;
    look();
    check("spec_ghr", {24'd0, o_ghr}, 32'h07);
    adv();
    i_com_br = 0; i_com_mispred = 0; i_fetch_adv = 0;
    look();
    check("repair_ghr", {24'd0, o_ghr}, 32'h02);
    adv();
    // saturation: wrap-around would leave the counter not-taken
    for (int n = 0; n < 4; n++) commit(32'h6000, 8'h02, 32'h6600, 1, 0);
    commit(32'h6000, 8'h02, 32'h6600, 0, 0);
    i_pc = 32'h6000; i_lane_vld = 2'b01;
    look();
    check("sat_taken", {31'd0, o_pred_taken}, 32'd1);
    check("sat_tgt", o_pred_tgt, 32'h6600);
    adv();
    // perf counters: 5 predicted-taken groups, 2 mispredicts
    rst = 1;
    look();
    adv();
    rst = 0;
    foreach (m_vld[i]) if (i < 5) for (int n = 0; n < 2; n++) commit(32'h3000, 8'((1 << i) - 1), 32'h3000, 1, 0);
    i_pc = 32'h3000; i_lane_vld = 2'b01; i_fetch_adv = 1;
    for (int n = 0; n < 5; n++) begin
      look();
      adv();
    end
    i_fetch_adv = 0;
    for (int n = 0; n < 2; n++) commit(32'h3000, 8'h00, 32'h3000, 1, 1);
    look();
    check("perf_pred5", o_perf_pred, PERF ? 32'd5 : 32'd0);
    check("perf_mis2", o_perf_mispred, PERF ? 32'd2 : 32'd0);
    adv();
    // random traffic with BTB aliasing and PC wrap
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      i_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
           : (($urandom_range(0, 1) ? 32'h3000 : 32'h7000) + 32'(4 * $urandom_range(0, 15)));
      i_lane_vld = 2'($urandom_range(0, 3));
      i_fetch_adv = 1'($urandom_range(0, 1));
      i_com_br = 1'($urandom_range(0, 1));
      i_com_pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
               : (($urandom_range(0, 3) == 0 ? 32'h7000 : 32'h3000) + 32'(4 * $urandom_range(0, 16)));
      i_com_ghr = $urandom_range(0, 1) ? m_ghr : 8'($urandom);
      i_com_tgt = $urandom;
      i_com_taken = ($urandom_range(0, 3) != 0);
      i_com_mispred = ($urandom_range(0, 7) == 0);
      look();
      adv();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/br_predictor_gs2.md
Name: br_predictor_gs2

Overview:
- Second-generation front-end branch predictor: parametrised fetch width, BTB depth and gshare PHT depth.
- Per-lane BTB (valid + tag) and 2-bit saturating-counter PHT; selects the first predicted-taken lane of the fetch group.
- Holds a speculative GHR, updated per accepted fetch group and repaired from the commit stage on mispredict.
- Sits between the PC-select and fetch stages; trained by the commit stage.

Parameters:
- FETCH_W, 2, lanes per fetch group (power of 2, ≥1)
- PC_W, 32, PC width
- BTB_ENTS, 64, BTB entries (power of 2), direct-mapped
- PHT_ENTS, 256, PHT entries (power of 2)
- GHR_W, 8, history width; must equal log2(PHT_ENTS) (elaboration error otherwise)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_pc  in  PC_W  fetch-group base PC; lane k PC = i_pc + 4*k
- i_lane_vld  in  FETCH_W  per-lane valid
- i_fetch_adv  in  1  fetch group accepted this cycle
- o_ghr  out  GHR_W  speculative GHR before this group's update, carried down the pipeline
- o_pred_taken  out  1  some valid lane predicted taken
- o_pred_lane  out  max(1,log2 FETCH_W)  lowest taken lane index
- o_pred_tgt  out  PC_W  BTB target of o_pred_lane
- i_com_br  in  1  branch committed
- i_com_pc  in  PC_W  committed branch PC
- i_com_ghr  in  GHR_W  GHR snapshot carried with the branch
- i_com_tgt  in  PC_W  resolved target
- i_com_taken  in  1  resolved direction
- i_com_mispred  in  1  direction or target mispredicted (qualified by i_com_br)
- o_perf_pred  out  32  predicted-taken group count (optional feature)
- o_perf_mispred  out  32  mispredict count (optional feature)

Behaviour:
- Lookup is combinational from flop arrays; predictions are valid in the same cycle as i_pc.
- BTB index = lanePC[2 +: log2 BTB_ENTS]; tag = lanePC[PC_W-1 : 2+log2 BTB_ENTS]. hit_k = i_lane_vld[k] & valid & tag match.
- PHT index_k = lanePC[2 +: GHR_W] ^ GHR. taken_k = hit_k & counter_k[1].
- o_pred_taken = OR of taken_k. o_pred_lane = lowest k with taken_k set. o_pred_tgt = that lane's target.
- When no lane is taken, o_pred_lane = 0 and o_pred_tgt = 0.
- GHR update priority, highest first:
  1. rst → 0.
  2. i_com_br & i_com_mispred → {i_com_ghr[GHR_W-2:0], i_com_taken}. Any same-cycle fetch update is dropped.
  3. i_fetch_adv & (any hit_k) → {GHR[GHR_W-2:0], o_pred_taken}. Exactly one shift per group.
  4. Otherwise hold.
- PHT training on i_com_br: entry at i_com_pc[2 +: GHR_W] ^ i_com_ghr increments when taken, decrements when not taken, saturating at 3 and 0.
- BTB training on i_com_br & i_com_taken: write valid = 1, tag, target at i_com_pc's index; overwrites any prior entry. Not-taken branches leave the BTB unchanged.
- Same-cycle commit write and lookup of the same entry: the lookup sees the pre-write value (no bypass).
- Reset state: all BTB valid = 0, all PHT counters = 2'b01 (weakly not-taken), GHR = 0, perf counters = 0.
- Outputs after reset: o_pred_taken = 0, o_pred_lane = 0, o_pred_tgt = 0, o_ghr = 0.
- rst asserted mid-operation wins over any same-cycle commit or fetch update.
- GHR wraps by shifting; the oldest bit is discarded. PC + 4*k wraps modulo 2^PC_W.

Optional Feature:
- Macro BRPRED_PERF_CNT_EN.
- When defined: o_perf_pred increments on each i_fetch_adv with o_pred_taken = 1; o_perf_mispred increments on each i_com_br & i_com_mispred. Both are 32-bit, wrap at 2^32, and are cleared by rst.
- When undefined: both ports remain and are tied to 0; no counter flops are built.

Test Plan:
- Reset: assert rst 2 cycles with i_pc=0x100, i_lane_vld=2'b11 → o_pred_taken=0, o_pred_lane=0, o_pred_tgt=0, o_ghr=0.
- BTB fill then counter warm-up at PC 0x1004 (lane 1 of base 0x1000):
  - one commit, taken, tgt 0x2000, i_com_ghr=0 → counter 01→10.
  - lookup i_pc=0x1000, GHR=0 → o_pred_taken=1, o_pred_lane=1, o_pred_tgt=0x2000.
- First-taken select: lanes 0 and 1 both hit and strongly taken, tgts 0x3000/0x4000 → o_pred_lane=0, o_pred_tgt=0x3000. Then clear i_lane_vld[0] → o_pred_lane=1, o_pred_tgt=0x4000.
- GHR speculate then repair:
  - three fetch_adv with a taken hit from GHR=0 → o_ghr=0x07.
  - then i_com_mispred, i_com_ghr=0x01, i_com_taken=0, with fetch_adv the same cycle → next o_ghr=0x02.
- Saturation: four taken commits to one entry → counter stays 11. Then one not-taken commit → 10, still predicts taken.
- With BRPRED_PERF_CNT_EN: 5 taken-predicted accepted groups and 2 mispredicts → o_perf_pred=5, o_perf_mispred=2. Without the macro → both 0.
